// File: rtl/dac_fmt_pkg.sv
// Shared format constants and elaboration helpers for the DAC word-clock re-timer.
package dac_fmt_pkg;

  localparam int unsigned TDM_DUAL = 0;
  localparam int unsigned TDM_MUX  = 1;
  localparam int unsigned FMT_LJ   = 0;
  localparam int unsigned FMT_I2S  = 1;
  localparam int unsigned MAX_HALF = 256;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit fmt_legal(input int unsigned half_bits, input int unsigned dac_bits,
                                   input int unsigned in_i2s, input int unsigned wclk_pos,
                                   input int unsigned lock_halves);
    return (half_bits >= 2) && (half_bits <= MAX_HALF) && (dac_bits >= 2) &&
           (in_i2s <= FMT_I2S) && (dac_bits + in_i2s <= half_bits) &&
           (wclk_pos < half_bits / 2) && (lock_halves >= 1);
  endfunction

  // Bit i set for lo <= i < hi; lets the datapath decode index windows by lookup.
  function automatic logic [MAX_HALF-1:0] win_mask(input int unsigned lo, input int unsigned hi);
    logic [MAX_HALF-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_HALF; i++) begin
      if (i >= lo && i < hi) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dac_wclk_gen_tracker.sv
// lrck edge detect, per-half bit index and frame-lock monitor.
module lrck_tracker
  import dac_fmt_pkg::*;
#(
  parameter int unsigned HALF_BITS   = 16,
  parameter int unsigned LOCK_HALVES = 4,
  localparam int unsigned CW         = cnt_w(HALF_BITS)
) (
  input  logic          bck_i,
  input  logic          rst_n_i,
  input  logic          lrck_i,
  output logic [CW-1:0] idx_o,
  output logic          edge_o,
  output logic          ch_o,
  output logic          locked_o
);

  localparam int unsigned GW        = cnt_w(LOCK_HALVES + 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(HALF_BITS - 1);
  localparam logic [GW-1:0] GOOD_SAT = GW'(LOCK_HALVES);

  logic          lrck_d_q;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          at_last;

  assign edge_o = lrck_i ^ lrck_d_q;

  // Edge exactly after the last bit is a good half; early edge or freewheel wrap is bad.
  always_comb begin
    at_last    = (bit_cnt_q == IDX_LAST);
    bit_cnt_d  = (edge_o || at_last) ? '0 : bit_cnt_q + 1'b1;
    good_cnt_d = good_cnt_q;
    if (edge_o && at_last) begin
      if (good_cnt_q != GOOD_SAT) good_cnt_d = good_cnt_q + 1'b1;
    end else if (edge_o || at_last) begin
      good_cnt_d = '0;
    end
  end

  assign idx_o    = bit_cnt_d;
  assign ch_o     = lrck_i;
  assign locked_o = (good_cnt_d == GOOD_SAT);

  always_ff @(posedge bck_i) begin
    if (!rst_n_i) begin
      lrck_d_q   <= 1'b0;
      bit_cnt_q  <= '0;
      good_cnt_q <= '0;
    end else begin
      lrck_d_q   <= lrck_i;
      bit_cnt_q  <= bit_cnt_d;
      good_cnt_q <= good_cnt_d;
    end
  end

endmodule

// File: rtl/dac_wclk_gen.sv
// Serial-audio re-timer: captures LJ/I2S words and re-emits them right-justified
// with a latch clock for one (L/R muxed) or two latch-type DACs.
module dac_wclk_gen
  import dac_fmt_pkg::*;
#(
  parameter int unsigned HALF_BITS   = 16,
  parameter int unsigned DAC_BITS    = 16,
  parameter int unsigned IN_I2S      = 0,
  parameter int unsigned TDM         = 1,
  parameter int unsigned WCLK_POS    = 0,
  parameter int unsigned LOCK_HALVES = 4
) (
  input  logic bck,
  input  logic rst_n,
  input  logic lrck,
  input  logic sdata,
  output logic dout_l,
  output logic dout_r,
  output logic wclk,
  output logic locked
);

  localparam int unsigned CW = cnt_w(HALF_BITS);
  localparam logic [CW-1:0] IDX_LAST = CW'(HALF_BITS - 1);
  localparam logic [CW-1:0] IDX_WR   = CW'(WCLK_POS);
  localparam logic [HALF_BITS-1:0] CAP_WIN   = HALF_BITS'(win_mask(IN_I2S, IN_I2S + DAC_BITS));
  localparam logic [HALF_BITS-1:0] SHIFT_WIN = HALF_BITS'(win_mask(HALF_BITS - DAC_BITS, HALF_BITS));
  localparam logic [HALF_BITS-1:0] WCLK_WIN  = HALF_BITS'(win_mask(WCLK_POS, WCLK_POS + HALF_BITS / 2));

  if (!fmt_legal(HALF_BITS, DAC_BITS, IN_I2S, WCLK_POS, LOCK_HALVES)) begin : g_bad_params
    $error("dac_wclk_gen: illegal HALF_BITS/DAC_BITS/IN_I2S/WCLK_POS/LOCK_HALVES combination");
  end

  logic [CW-1:0]       idx;
  logic                lr_edge, ch, lock_nxt;
  logic [DAC_BITS-1:0] cap_q, cap_d, cap_base, cap_word;
  logic [DAC_BITS-1:0] word_l_q, word_l_d;
  logic [DAC_BITS-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic                dout_l_q, dout_l_d, dout_r_q, dout_r_d;
  logic                wclk_q, wclk_d, locked_q;
  logic                xfer, shifting;

  lrck_tracker #(
    .HALF_BITS  (HALF_BITS),
    .LOCK_HALVES(LOCK_HALVES)
  ) u_tracker (
    .bck_i   (bck),
    .rst_n_i (rst_n),
    .lrck_i  (lrck),
    .idx_o   (idx),
    .edge_o  (lr_edge),
    .ch_o    (ch),
    .locked_o(lock_nxt)
  );

  // The transfer takes cap_d so the bit arriving on the last index is included.
  always_comb begin
    cap_base = lr_edge ? '0 : cap_q;
    cap_d    = cap_base;
    if (CAP_WIN[idx]) cap_d = {cap_base[DAC_BITS-2:0], sdata};
    cap_word = lock_nxt ? cap_d : '0;
    xfer     = (idx == IDX_LAST);
    shifting = SHIFT_WIN[idx];
    dout_l_d = lock_nxt & shifting & sh_l_q[DAC_BITS-1];
    dout_r_d = lock_nxt & shifting & sh_r_q[DAC_BITS-1];
    sh_l_d   = shifting ? (sh_l_q << 1) : sh_l_q;
    sh_r_d   = shifting ? (sh_r_q << 1) : sh_r_q;
    word_l_d = word_l_q;
    if (TDM == TDM_MUX) begin
      sh_r_d   = '0;
      dout_r_d = 1'b0;
      if (xfer) sh_l_d = cap_word;
      wclk_d = WCLK_WIN[idx];
    end else begin
      if (xfer) begin
        if (ch) begin
          word_l_d = cap_word;
        end else begin
          sh_l_d = lock_nxt ? word_l_q : '0;
          sh_r_d = cap_word;
        end
      end
      wclk_d = (idx == IDX_WR) ? ~ch : wclk_q;
    end
  end

  always_ff @(posedge bck) begin
    if (!rst_n) begin
      cap_q    <= '0;
      word_l_q <= '0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      dout_l_q <= 1'b0;
      dout_r_q <= 1'b0;
      wclk_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      word_l_q <= word_l_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      dout_l_q <= dout_l_d;
      dout_r_q <= dout_r_d;
      wclk_q   <= wclk_d;
      locked_q <= lock_nxt;
    end
  end

  assign dout_l = dout_l_q;
  assign dout_r = dout_r_q;
  assign wclk   = wclk_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_dac_wclk_gen.sv
// Directed bench: muxed 16-bit LJ instance (A) and dual 24-bit I2S instance (B).
module tb_dac_wclk_gen;

  logic bck = 1'b0;
  always #5 bck = ~bck;

  logic rst_a_n, lrck_a, sdata_a, dout_l_a, dout_r_a, wclk_a, locked_a;
  logic rst_b_n, lrck_b, sdata_b, dout_l_b, dout_r_b, wclk_b, locked_b;

  dac_wclk_gen #(
    .HALF_BITS(16), .DAC_BITS(16), .IN_I2S(0), .TDM(1), .WCLK_POS(0), .LOCK_HALVES(4)
  ) u_a (
    .bck(bck), .rst_n(rst_a_n), .lrck(lrck_a), .sdata(sdata_a),
    .dout_l(dout_l_a), .dout_r(dout_r_a), .wclk(wclk_a), .locked(locked_a)
  );

  dac_wclk_gen #(
    .HALF_BITS(32), .DAC_BITS(24), .IN_I2S(1), .TDM(0), .WCLK_POS(0), .LOCK_HALVES(4)
  ) u_b (
    .bck(bck), .rst_n(rst_b_n), .lrck(lrck_b), .sdata(sdata_b),
    .dout_l(dout_l_b), .dout_r(dout_r_b), .wclk(wclk_b), .locked(locked_b)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic ob_l [64];
  logic ob_r [64];
  logic ob_w [64];
  logic ob_k [64];
  logic [31:0] got;

  function automatic logic [31:0] pack(input int unsigned sel, input int unsigned first,
                                       input int unsigned n);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = first; i < first + n; i++) begin
      case (sel)
        0:       v = {v[30:0], ob_l[i]};
        1:       v = {v[30:0], ob_r[i]};
        2:       v = {v[30:0], ob_w[i]};
        default: v = {v[30:0], ob_k[i]};
      endcase
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge bck);
    #1;
  endtask

  task automatic send_half_a(input logic lr, input logic [15:0] w, input int unsigned len);
    logic [15:0] d;
    d = w;
    for (int unsigned k = 0; k < len; k++) begin
      lrck_a = lr; sdata_a = d[15]; d = d << 1;
      tick();
      ob_l[k] = dout_l_a; ob_r[k] = dout_r_a; ob_w[k] = wclk_a; ob_k[k] = locked_a;
    end
  endtask

  task automatic send_half_b(input logic lr, input logic [23:0] w);
    logic [24:0] d;
    d = {1'b0, w};
    for (int unsigned k = 0; k < 32; k++) begin
      lrck_b = lr; sdata_b = d[24]; d = d << 1;
      tick();
      ob_l[k] = dout_l_b; ob_r[k] = dout_r_b; ob_w[k] = wclk_b; ob_k[k] = locked_b;
    end
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; lrck_a = 1'b0; sdata_a = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({dout_l_a, dout_r_a, wclk_a, locked_a} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000", {dout_l_a, dout_r_a, wclk_a, locked_a});
    end
    rst_a_n = 1'b1;
  endtask

  task automatic test_lock_acquire();
    for (int unsigned h = 0; h < 4; h++) begin
      send_half_a((h % 2) == 0, 16'hFFFF, 16);
      got = pack(0, 0, 16);
      n_cmp++;
      if (got !== 32'h0) begin
        n_bad++; $display("FAIL acq_dout_half%0d: got %h want 0", h, got);
      end
      got = pack(3, 0, 16);
      n_cmp++;
      if (got !== 32'h0) begin
        n_bad++; $display("FAIL acq_locked_half%0d: got %h want 0", h, got);
      end
    end
    send_half_a(1'b1, 16'hA5C3, 16);
    n_cmp++;
    if (ob_k[0] !== 1'b1) begin
      n_bad++; $display("FAIL acq_lock_rise: got %b want 1", ob_k[0]);
    end
    got = pack(0, 0, 16);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++; $display("FAIL acq_unlocked_word_muted: got %h want 0", got);
    end
  endtask

  task automatic test_tdm_mux();
    send_half_a(1'b0, 16'h0F0F, 16);
    got = pack(0, 0, 16);
    n_cmp++;
    if (got !== 32'hA5C3) begin
      n_bad++; $display("FAIL mux_word_l: got %h want a5c3", got);
    end
    got = pack(2, 0, 16);
    n_cmp++;
    if (got !== 32'hFF00) begin
      n_bad++; $display("FAIL mux_wclk_r_half: got %h want ff00", got);
    end
    send_half_a(1'b1, 16'h0000, 16);
    got = pack(0, 0, 16);
    n_cmp++;
    if (got !== 32'h0F0F) begin
      n_bad++; $display("FAIL mux_word_r: got %h want 0f0f", got);
    end
    got = pack(2, 0, 16);
    n_cmp++;
    if (got !== 32'hFF00) begin
      n_bad++; $display("FAIL mux_wclk_l_half: got %h want ff00", got);
    end
    got = pack(1, 0, 16);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++; $display("FAIL mux_dout_r_idle: got %h want 0", got);
    end
  endtask

  task automatic test_early_edge();
    send_half_a(1'b0, 16'h1234, 16);
    send_half_a(1'b1, 16'hFFFF, 15);
    got = pack(0, 0, 15);
    n_cmp++;
    if (got !== 32'h091A) begin
      n_bad++; $display("FAIL early_prev_word: got %h want 091a", got);
    end
    n_cmp++;
    if (ob_k[14] !== 1'b1) begin
      n_bad++; $display("FAIL early_lock_before: got %b want 1", ob_k[14]);
    end
    send_half_a(1'b0, 16'h5555, 16);
    n_cmp++;
    if (ob_k[0] !== 1'b0) begin
      n_bad++; $display("FAIL early_lock_drop: got %b want 0", ob_k[0]);
    end
    got = pack(0, 0, 16);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++; $display("FAIL early_word_zero: got %h want 0", got);
    end
    send_half_a(1'b1, 16'h5555, 16);
    send_half_a(1'b0, 16'h5555, 16);
    send_half_a(1'b1, 16'h5555, 16);
    n_cmp++;
    if (ob_k[15] !== 1'b0) begin
      n_bad++; $display("FAIL relock_not_early: got %b want 0", ob_k[15]);
    end
    send_half_a(1'b0, 16'h3C3C, 16);
    n_cmp++;
    if (ob_k[0] !== 1'b1) begin
      n_bad++; $display("FAIL relock_rise: got %b want 1", ob_k[0]);
    end
    got = pack(0, 0, 16);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++; $display("FAIL relock_prev_muted: got %h want 0", got);
    end
    send_half_a(1'b1, 16'h0000, 16);
    got = pack(0, 0, 16);
    n_cmp++;
    if (got !== 32'h3C3C) begin
      n_bad++; $display("FAIL relock_word: got %h want 3c3c", got);
    end
  endtask

  task automatic test_freewheel();
    send_half_a(1'b0, 16'h0000, 40);
    n_cmp++;
    if (ob_k[15] !== 1'b1) begin
      n_bad++; $display("FAIL fw_lock_before_wrap: got %b want 1", ob_k[15]);
    end
    n_cmp++;
    if (ob_k[16] !== 1'b0) begin
      n_bad++; $display("FAIL fw_lock_after_wrap: got %b want 0", ob_k[16]);
    end
    for (int unsigned k = 0; k < 40; k++) begin
      n_cmp++;
      if (ob_w[k] !== ((k % 16) < 8)) begin
        n_bad++; $display("FAIL fw_wclk_tick%0d: got %b want %b", k, ob_w[k], ((k % 16) < 8));
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    rst_a_n = 1'b0; lrck_a = 1'b0; sdata_a = 1'b0;
    repeat (2) tick();
    rst_a_n = 1'b1;
    for (int unsigned h = 0; h < 4; h++) send_half_a((h % 2) == 0, 16'hFFFF, 16);
    send_half_a(1'b1, 16'hA5C3, 16);
    send_half_a(1'b0, 16'h0F0F, 6);
    got = pack(0, 0, 6);
    n_cmp++;
    if (got !== 32'h29) begin
      n_bad++; $display("FAIL rst_pre_shift: got %h want 29", got);
    end
    for (int unsigned k = 0; k < 3; k++) begin
      rst_a_n = 1'b0; lrck_a = 1'b0; sdata_a = 1'b0;
      tick();
      n_cmp++;
      if ({dout_l_a, dout_r_a, wclk_a, locked_a} !== 4'b0000) begin
        n_bad++;
        $display("FAIL rst_mid_tick%0d: got %b want 0000", k, {dout_l_a, dout_r_a, wclk_a, locked_a});
      end
    end
    rst_a_n = 1'b1;
    for (int unsigned h = 0; h < 3; h++) begin
      send_half_a((h % 2) == 0, 16'hFFFF, 16);
      got = {pack(0, 0, 16)[15:0], pack(3, 0, 16)[15:0]};
      n_cmp++;
      if (got !== 32'h0) begin
        n_bad++; $display("FAIL rst_after_half%0d: got %h want 0", h, got);
      end
    end
  endtask

  task automatic test_dual();
    rst_b_n = 1'b1;
    for (int unsigned h = 0; h < 4; h++) send_half_b((h % 2) == 0, 24'hFFFFFF);
    send_half_b(1'b1, 24'h800001);
    n_cmp++;
    if (ob_k[0] !== 1'b1) begin
      n_bad++; $display("FAIL dual_lock_rise: got %b want 1", ob_k[0]);
    end
    got = pack(0, 0, 32);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++; $display("FAIL dual_unlocked_muted: got %h want 0", got);
    end
    send_half_b(1'b0, 24'h7FFFFE);
    n_cmp++;
    if (ob_w[0] !== 1'b1) begin
      n_bad++; $display("FAIL dual_wclk_rise_r: got %b want 1", ob_w[0]);
    end
    send_half_b(1'b1, 24'h000000);
    got = pack(0, 0, 8);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++; $display("FAIL dual_l_lead_zero: got %h want 0", got);
    end
    got = pack(0, 8, 24);
    n_cmp++;
    if (got !== 32'h800001) begin
      n_bad++; $display("FAIL dual_word_l: got %h want 800001", got);
    end
    got = pack(1, 0, 32);
    n_cmp++;
    if (got !== 32'h007FFFFE) begin
      n_bad++; $display("FAIL dual_word_r: got %h want 007ffffe", got);
    end
    got = pack(2, 0, 32);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++; $display("FAIL dual_wclk_l_half: got %h want 0", got);
    end
    send_half_b(1'b0, 24'h000000);
    got = pack(2, 0, 32);
    n_cmp++;
    if (got !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL dual_wclk_r_half: got %h want ffffffff", got);
    end
    got = pack(0, 0, 32) | pack(1, 0, 32);
    n_cmp++;
    if (got !== 32'h0) begin
      n_bad++; $display("FAIL dual_r_half_quiet: got %h want 0", got);
    end
  endtask

  initial begin
    rst_b_n = 1'b0; lrck_b = 1'b0; sdata_b = 1'b0;
    test_reset();
    test_lock_acquire();
    test_tdm_mux();
    test_early_edge();
    test_freewheel();
    test_reset_mid_shift();
    test_dual();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dac_wclk_gen.md
# dac_wclk_gen

Parametrised serial-audio re-timer for multibit latch-type DACs. It sits between the LJ/I2S receiver output (bck/lrck/sdata) and one or two DAC chips. It captures each channel word, re-emits it right-justified with a latch clock (wclk), and supports both stereo dual-DAC and single-DAC L/R time-multiplexed modes. A frame-lock monitor mutes the outputs while the incoming frame structure is invalid.

## Interface
- HALF_BITS, 16: bck cycles per lrck half-period (16 = 32fs, 32 = 64fs).
- DAC_BITS, 16: bits per output word. Must satisfy DAC_BITS + IN_I2S ≤ HALF_BITS, otherwise elaboration error.
- IN_I2S, 0: 0 = LJ input (MSB on first bck of half), 1 = I2S input (MSB on second bck).
- TDM, 1: 1 = single DAC with L/R time-multiplexed on dout_l; 0 = two DACs on dout_l/dout_r.
- WCLK_POS, 0: bit index within a half at which wclk rises. Must be < HALF_BITS/2.
- LOCK_HALVES, 4: consecutive valid halves required to assert locked.
- bck  in  1  bit clock; the only clock. All logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- lrck  in  1  frame sync, 1 = L channel.
- sdata  in  1  serial data, MSB first.
- dout_l  out  1  serial word, L (or L/R muxed when TDM=1).
- dout_r  out  1  serial word, R (held 0 when TDM=1).
- wclk  out  1  DAC latch clock; the DAC latches on the rising edge.
- locked  out  1  frame structure valid.

## Operation
- lrck and sdata are registered on every bck rising edge. edge = (lrck != lrck_d).
- Bit index idx:
  - idx = 0 on an edge cycle; otherwise idx = bit_cnt+1.
  - Wraps to 0 after HALF_BITS-1 when no edge arrives (freewheel).
  - bit_cnt <= idx.
- Capture: sdata is shifted into cap when IN_I2S ≤ idx < IN_I2S+DAC_BITS. Other bits are ignored.
- Transfer at idx == HALF_BITS-1:
  - TDM=1: cap → out_word. Channel tag = lrck_d.
  - TDM=0: cap → word_l or word_r per lrck_d. On the R half's transfer, both words move into the shift registers.
- Shift-out in the following half (L half for TDM=0), right-justified:
  - dout = 0 for idx < HALF_BITS-DAC_BITS.
  - Then word bits MSB first, so the LSB occupies idx = HALF_BITS-1.
- wclk:
  - TDM=1: rises at idx == WCLK_POS of the half after a word's shift-out; falls at WCLK_POS + HALF_BITS/2. One latch per channel.
  - TDM=0: rises at idx == WCLK_POS of the R half; falls at idx == WCLK_POS of the L half. One latch per frame.
- Lock monitor:
  - A half is good when its edge arrives exactly when bit_cnt == HALF_BITS-1.
  - Bad when an edge arrives early, or on a freewheel wrap.
  - A good half increments good_cnt (saturating). A bad half clears good_cnt and deasserts locked immediately.
  - locked = 1 when good_cnt ≥ LOCK_HALVES.
- Mute: while locked = 0, dout_l/dout_r are forced 0 and the words transferred are zeroed. wclk keeps running from the counter, so the DAC latches zero.
- Reset: all outputs 0. bit_cnt, lrck_d, cap, words, shift registers and good_cnt are 0. Reset mid-frame drops any partial word. Relock requires LOCK_HALVES good halves after reset release.

## Timing
- All outputs are registered and change only after a bck rising edge. The DAC is clocked from inverted bck at board level.
- Latency: a word captured in half n is fully shifted out by the end of half n+1 and latched by wclk rising in half n+2.
- Simultaneous edge and idx == HALF_BITS-1 (lrck changes in the cycle after the last bit) is the normal case: the transfer and the new half start are both taken.
- An early edge aborts capture. The partial word is discarded, output is 0 for that channel, and locked drops in the same cycle.

## Structure
- Package dac_fmt_pkg:
  - Mode constants: TDM_MUX, TDM_DUAL, FMT_LJ, FMT_I2S.
  - Counter width function: clog2(HALF_BITS).
  - Parameter legality checks.
- Sub-module lrck_tracker: edge detect, bit counter, lock monitor.
  - Outputs: idx, edge, ch, locked.
- Top level holds capture, transfer and shift registers plus wclk generation.

## Test plan
- TDM=1, HALF_BITS=16, DAC_BITS=16, LJ; send L=0xA5C3, R=0x0F0F after lock.
  - dout_l shows 0xA5C3 in the next R half, then 0x0F0F.
  - wclk rises at idx 0 of each following half and stays high 8 cycles.
- TDM=0, HALF_BITS=32, DAC_BITS=24, I2S; L=0x800001, R=0x7FFFFE.
  - Both appear concurrently in the next L half on dout_l/dout_r, starting at idx 8.
  - wclk rises at idx 0 of the R half.
- Reset release with a clean stream: locked = 0 for the first 4 halves and asserts at the end of the 4th. dout stays 0 until then.
- Shorten one half to 15 bck: locked drops on the early-edge cycle, and that word is output as 0. Relock after 4 good halves.
- Hold lrck static for 40 bck: freewheel wrap at 16 clears locked, while wclk continues toggling.
- Assert rst_n = 0 for 3 cycles mid-shift: all outputs read 0 on the cycle after the sampled reset, and the partial word is not emitted.
